// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, the default bubble word,
// and the fetch FSM / redirect-kind enumerations.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // bltz lives under OP_REGIMM with rt = 0
    localparam logic [4:0] RT_BLTZ    = 5'h00;

    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {BOOT, RUN, PEND} fetch_state_e;
    typedef enum logic [1:0] {RD_NONE, RD_J, RD_JR, RD_BR} redirect_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: decoder redirect flags, instruction-memory bus and the
// issued instruction. master = fetch unit, slave = its environment.
interface fetch_unit_if;

    logic        stall;
    logic        jump_del;
    logic        branch_del;
    logic        branch_taken;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    modport master (
        input  stall, jump_del, branch_del, branch_taken, jr_target, imem_rdata,
        output imem_addr, instruction, pc, pc_plus4, instr_valid
    );

    modport slave (
        output stall, jump_del, branch_del, branch_taken, jr_target, imem_rdata,
        input  imem_addr, instruction, pc, pc_plus4, instr_valid
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational redirect decode: classifies the delayed control flags and
// computes the j / jr / bltz target from the previously issued instruction.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] instr_q,
    input  logic [31:0] pc_q,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic        jump_del,
    input  logic        branch_del,
    output redirect_e   kind,
    output logic [31:0] target
);

    logic [31:0] seq_pc;
    logic        unused_bits;

    assign seq_pc      = pc_q + 32'd4;
    assign unused_bits = ^{jr_target[1:0], instr_q[31:26]};

    always_comb begin
        kind   = RD_NONE;
        target = seq_pc;
        case ({jump_del, branch_del})
            2'b11: begin
                kind   = RD_JR;
                target = {jr_target[31:2], 2'b00};
            end
            2'b10: begin
                kind   = RD_J;
                target = {seq_pc[31:28], instr_q[25:0], 2'b00};
            end
            2'b01: begin
                // an untaken bltz is not a redirect at all
                if (branch_taken) begin
                    kind   = RD_BR;
                    target = seq_pc + branch_offset(instr_q[15:0]);
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage with a one-slot branch delay.
// Optional macro FETCH_FLUSH_EN squashes the delay slot to a NOP bubble.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_e state_reg;
    fetch_state_e state_next;

    logic [31:0] fetch_pc_reg;     // next sequential address to present
    logic [31:0] rd_addr_reg;      // address whose word is on imem_rdata now
    logic [31:0] pend_target_reg;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;

    redirect_e   kind;
    logic [31:0] target;
    logic        redirect_now;
    logic        issuing;
    logic [31:0] fetch_addr;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        issue_valid;

    pc_target_calc u_target (
        .instr_q      (instr_q),
        .pc_q         (pc_q),
        .jr_target    (bus.jr_target),
        .branch_taken (bus.branch_taken),
        .jump_del     (bus.jump_del),
        .branch_del   (bus.branch_del),
        .kind         (kind),
        .target       (target)
    );

    // Flags are honoured only in RUN; once PEND holds a target the first one wins.
    assign redirect_now = (state_reg == RUN) && (kind != RD_NONE);
    assign issuing      = (state_reg != BOOT) && !bus.stall;

`ifdef FETCH_FLUSH_EN
    logic slot_redirect;
    assign slot_redirect = !bus.stall &&
                           (((state_reg == RUN) && redirect_now) || (state_reg == PEND));
`endif

    always_comb begin
        fetch_addr = fetch_pc_reg;
        case (state_reg)
            BOOT: fetch_addr = RESET_PC;
            RUN: begin
                if (bus.stall)         fetch_addr = rd_addr_reg;
                else if (redirect_now) fetch_addr = target;
            end
            PEND: fetch_addr = bus.stall ? rd_addr_reg : pend_target_reg;
            default: fetch_addr = fetch_pc_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT: state_next = RUN;
            RUN:  if (redirect_now && bus.stall) state_next = PEND;
            PEND: if (!bus.stall) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        issue_instr = instr_q;
        issue_pc    = pc_q;
        issue_valid = valid_q;
        if (issuing) begin
            issue_instr = bus.imem_rdata;
            issue_pc    = rd_addr_reg;
            issue_valid = 1'b1;
`ifdef FETCH_FLUSH_EN
            if (slot_redirect) begin
                issue_instr = NOP_WORD;
                issue_valid = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            rd_addr_reg     <= RESET_PC;
            pend_target_reg <= RESET_PC;
            instr_q         <= NOP_WORD;
            pc_q            <= RESET_PC;
            valid_q         <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (redirect_now && bus.stall)
                pend_target_reg <= target;
            // BOOT always advances so the reset address is fetched exactly once
            if (!bus.stall || (state_reg == BOOT)) begin
                fetch_pc_reg <= fetch_addr + 32'd4;
                rd_addr_reg  <= fetch_addr;
            end
            if (issuing) begin
                instr_q <= issue_instr;
                pc_q    <= issue_pc;
                valid_q <= issue_valid;
            end
        end
    end

    assign bus.imem_addr   = fetch_addr;
    assign bus.instruction = issue_instr;
    assign bus.pc          = issue_pc;
    assign bus.pc_plus4    = issue_pc + 32'd4;
    assign bus.instr_valid = issue_valid;

endmodule
